// File: rtl/calc_key_entry.sv
// Keypad entry sequencer feeding the combinational calculator: builds a/b/operand
// from single-cycle key codes, pulses op_valid on '=', and chains result_in back into a.
module calc_key_entry #(
  parameter int nb         = 40,
  parameter int MAX_DIGITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [4:0]           key_code,
  input  logic signed [nb-1:0] result_in,
  output logic signed [nb-1:0] a,
  output logic signed [nb-1:0] b,
  output logic [2:0]           operand,
  output logic                 op_valid,
  output logic signed [nb-1:0] entry_value,
  output logic [3:0]           digit_cnt,
  output logic                 key_err
);

  localparam logic [1:0] ENTER_A = 2'd0;
  localparam logic [1:0] ENTER_B = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Extra headroom so mag*10+d can be compared against the limit without wrapping.
  localparam int             WW    = nb + 4;
  localparam logic [WW-1:0]  LIMIT = (WW'(1) << (nb - 1)) - WW'(1);

  logic [1:0]           state, state_n;
  logic [nb-2:0]        mag, mag_n, base_mag;
  logic                 sign, sign_n;
  logic [3:0]           cnt_n, base_cnt;
  logic [WW-1:0]        wide;
  logic signed [nb-1:0] a_n, b_n, ev_n;
  logic [2:0]           op_n;
  logic                 opv_n, err_n;

  always_comb begin
    state_n  = state;
    mag_n    = mag;
    sign_n   = sign;
    cnt_n    = digit_cnt;
    a_n      = a;
    b_n      = b;
    op_n     = operand;
    opv_n    = 1'b0;
    err_n    = 1'b0;
    // A digit after '=' starts a fresh entry rather than extending B.
    base_mag = (state == DONE) ? '0 : mag;
    base_cnt = (state == DONE) ? '0 : digit_cnt;
    wide     = WW'(base_mag) * WW'(10) + WW'(key_code[3:0]);

    if (key_valid) begin
      if (key_code < 5'd10) begin
        if (base_cnt < 4'(MAX_DIGITS) && wide <= LIMIT) begin
          mag_n = wide[nb-2:0];
          cnt_n = base_cnt + 4'd1;
          if (state == DONE) begin
            sign_n  = 1'b0;
            state_n = ENTER_A;
          end
        end else begin
          err_n = 1'b1;
        end
      end else if (key_code <= 5'd14) begin
        case (state)
          ENTER_A: begin
            a_n     = entry_value;
            op_n    = 3'(key_code - 5'd10);
            mag_n   = '0;
            sign_n  = 1'b0;
            cnt_n   = '0;
            state_n = ENTER_B;
          end
          ENTER_B: begin
            if (digit_cnt == 4'd0) op_n = 3'(key_code - 5'd10);
            else                   err_n = 1'b1;
          end
          default: begin
            a_n     = result_in;
            op_n    = 3'(key_code - 5'd10);
            mag_n   = '0;
            sign_n  = 1'b0;
            cnt_n   = '0;
            state_n = ENTER_B;
          end
        endcase
      end else if (key_code == 5'd15) begin
        // Entry is left intact so the display keeps showing B.
        if (state == ENTER_B) begin
          b_n     = entry_value;
          opv_n   = 1'b1;
          state_n = DONE;
        end else begin
          err_n = 1'b1;
        end
      end else if (key_code == 5'd16) begin
        a_n     = '0;
        b_n     = '0;
        op_n    = '0;
        mag_n   = '0;
        sign_n  = 1'b0;
        cnt_n   = '0;
        state_n = ENTER_A;
      end else if (key_code == 5'd17) begin
        if (state == DONE) err_n  = 1'b1;
        else               sign_n = ~sign;
      end else begin
        err_n = 1'b1;
      end
    end

    ev_n = sign_n ? -{1'b0, mag_n} : {1'b0, mag_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ENTER_A;
      mag         <= '0;
      sign        <= 1'b0;
      digit_cnt   <= '0;
      a           <= '0;
      b           <= '0;
      operand     <= '0;
      op_valid    <= 1'b0;
      key_err     <= 1'b0;
      entry_value <= '0;
    end else begin
      state       <= state_n;
      mag         <= mag_n;
      sign        <= sign_n;
      digit_cnt   <= cnt_n;
      a           <= a_n;
      b           <= b_n;
      operand     <= op_n;
      op_valid    <= opv_n;
      key_err     <= err_n;
      entry_value <= ev_n;
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: one task per scenario, outputs sampled on the falling edge.
module tb_calc_key_entry;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               key_valid = 1'b0;
  logic [4:0]         key_code = '0;
  logic signed [39:0] result_in = '0;
  logic signed [39:0] a, b, entry_value;
  logic [2:0]         operand;
  logic               op_valid, key_err;
  logic [3:0]         digit_cnt;

  logic signed [40:0] result_in41 = '0;
  logic signed [40:0] a41, b41, ev41;
  logic [2:0]         operand41;
  logic               op_valid41, key_err41;
  logic [3:0]         cnt41;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  calc_key_entry #(.nb(40), .MAX_DIGITS(12)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .result_in(result_in), .a(a), .b(b), .operand(operand), .op_valid(op_valid),
    .entry_value(entry_value), .digit_cnt(digit_cnt), .key_err(key_err)
  );

  calc_key_entry #(.nb(41), .MAX_DIGITS(12)) u41 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .result_in(result_in41), .a(a41), .b(b41), .operand(operand41), .op_valid(op_valid41),
    .entry_value(ev41), .digit_cnt(cnt41), .key_err(key_err41)
  );

  // Called at a falling edge; returns at the next falling edge with the key consumed.
  task automatic press(input logic [4:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (a !== 40'sd0 || b !== 40'sd0 || operand !== 3'd0) begin
      fails++; $display("FAIL reset_abop: a=%0d b=%0d op=%0d want 0", a, b, operand); end
    tests++; if (op_valid !== 1'b0 || key_err !== 1'b0 || entry_value !== 40'sd0 || digit_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_misc: opv=%b err=%b ev=%0d cnt=%0d want 0", op_valid, key_err, entry_value, digit_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    press(5'd1); press(5'd2);
    tests++; if (entry_value !== 40'sd12 || digit_cnt !== 4'd2) begin
      fails++; $display("FAIL add_entry: ev=%0d cnt=%0d want 12/2", entry_value, digit_cnt); end
    press(5'd10);
    tests++; if (a !== 40'sd12 || operand !== 3'd0 || entry_value !== 40'sd0 || digit_cnt !== 4'd0) begin
      fails++; $display("FAIL add_op: a=%0d op=%0d ev=%0d cnt=%0d want 12/0/0/0", a, operand, entry_value, digit_cnt); end
    press(5'd3); press(5'd4); press(5'd15);
    tests++; if (b !== 40'sd34 || op_valid !== 1'b1 || entry_value !== 40'sd34 || a !== 40'sd12) begin
      fails++; $display("FAIL add_eq: b=%0d opv=%b ev=%0d a=%0d want 34/1/34/12", b, op_valid, entry_value, a); end
    @(negedge clk);
    tests++; if (op_valid !== 1'b0 || b !== 40'sd34) begin
      fails++; $display("FAIL add_pulse: opv=%b b=%0d want 0/34", op_valid, b); end
    press(5'd17);
    tests++; if (key_err !== 1'b1 || entry_value !== 40'sd34) begin
      fails++; $display("FAIL add_done: err=%b ev=%0d want 1/34", key_err, entry_value); end
  endtask

  task automatic test_negate_chain();
    press(5'd16);
    press(5'd5); press(5'd17);
    tests++; if (entry_value !== -40'sd5) begin
      fails++; $display("FAIL neg_entry: ev=%0d want -5", entry_value); end
    press(5'd12); press(5'd7); press(5'd17); press(5'd15);
    tests++; if (a !== -40'sd5 || operand !== 3'd2 || b !== -40'sd7 || op_valid !== 1'b1) begin
      fails++; $display("FAIL neg_eq: a=%0d op=%0d b=%0d opv=%b want -5/2/-7/1", a, operand, b, op_valid); end
    result_in = 40'sd35;
    press(5'd11);
    tests++; if (a !== 40'sd35 || operand !== 3'd1 || op_valid !== 1'b0 || key_err !== 1'b0) begin
      fails++; $display("FAIL chain_op: a=%0d op=%0d opv=%b err=%b want 35/1/0/0", a, operand, op_valid, key_err); end
    press(5'd1); press(5'd15);
    tests++; if (a !== 40'sd35 || operand !== 3'd1 || b !== 40'sd1 || op_valid !== 1'b1) begin
      fails++; $display("FAIL chain_eq: a=%0d op=%0d b=%0d opv=%b want 35/1/1/1", a, operand, b, op_valid); end
    result_in = '0;
  endtask

  task automatic test_digit_limit();
    press(5'd16);
    for (int i = 0; i < 11; i++) press(5'd9);
    tests++; if (entry_value !== 40'sd99999999999 || digit_cnt !== 4'd11 || key_err !== 1'b0) begin
      fails++; $display("FAIL lim_11: ev=%0d cnt=%0d err=%b want 99999999999/11/0", entry_value, digit_cnt, key_err); end
    press(5'd9);
    tests++; if (key_err !== 1'b1 || entry_value !== 40'sd99999999999 || digit_cnt !== 4'd11) begin
      fails++; $display("FAIL lim_ovf: err=%b ev=%0d cnt=%0d want 1/99999999999/11", key_err, entry_value, digit_cnt); end
    tests++; if (key_err41 !== 1'b0 || ev41 !== 41'sd999999999999 || cnt41 !== 4'd12) begin
      fails++; $display("FAIL lim41_12: err=%b ev=%0d cnt=%0d want 0/999999999999/12", key_err41, ev41, cnt41); end
    press(5'd9);
    tests++; if (key_err !== 1'b1 || digit_cnt !== 4'd11) begin
      fails++; $display("FAIL lim_13: err=%b cnt=%0d want 1/11", key_err, digit_cnt); end
    tests++; if (key_err41 !== 1'b1 || ev41 !== 41'sd999999999999 || cnt41 !== 4'd12) begin
      fails++; $display("FAIL lim41_13: err=%b ev=%0d cnt=%0d want 1/999999999999/12", key_err41, ev41, cnt41); end
    @(negedge clk);
    tests++; if (key_err !== 1'b0) begin
      fails++; $display("FAIL lim_pulse: err=%b want 0", key_err); end
  endtask

  task automatic test_op_replace();
    press(5'd16);
    press(5'd8); press(5'd10); press(5'd12);
    tests++; if (operand !== 3'd2 || a !== 40'sd8 || key_err !== 1'b0) begin
      fails++; $display("FAIL rep_op: op=%0d a=%0d err=%b want 2/8/0", operand, a, key_err); end
    press(5'd3); press(5'd13);
    tests++; if (key_err !== 1'b1 || operand !== 3'd2 || a !== 40'sd8 || entry_value !== 40'sd3) begin
      fails++; $display("FAIL rep_rej: err=%b op=%0d a=%0d ev=%0d want 1/2/8/3", key_err, operand, a, entry_value); end
  endtask

  task automatic test_bad_keys();
    press(5'd16);
    press(5'd15);
    tests++; if (key_err !== 1'b1 || op_valid !== 1'b0 || b !== 40'sd0) begin
      fails++; $display("FAIL bad_eq: err=%b opv=%b b=%0d want 1/0/0", key_err, op_valid, b); end
    press(5'd20);
    tests++; if (key_err !== 1'b1 || entry_value !== 40'sd0) begin
      fails++; $display("FAIL bad_code: err=%b ev=%0d want 1/0", key_err, entry_value); end
    press(5'd1); press(5'd14); press(5'd2); press(5'd15);
    tests++; if (op_valid !== 1'b1 || operand !== 3'd4 || a !== 40'sd1 || b !== 40'sd2) begin
      fails++; $display("FAIL bad_pow: opv=%b op=%0d a=%0d b=%0d want 1/4/1/2", op_valid, operand, a, b); end
    press(5'd17);
    tests++; if (key_err !== 1'b1 || entry_value !== 40'sd2 || op_valid !== 1'b0) begin
      fails++; $display("FAIL bad_neg: err=%b ev=%0d opv=%b want 1/2/0", key_err, entry_value, op_valid); end
    // Confirms negate left the sequencer in DONE: a digit restarts entry in ENTER_A.
    press(5'd6);
    tests++; if (entry_value !== 40'sd6 || digit_cnt !== 4'd1 || key_err !== 1'b0) begin
      fails++; $display("FAIL done_digit: ev=%0d cnt=%0d err=%b want 6/1/0", entry_value, digit_cnt, key_err); end
  endtask

  task automatic test_reset_clear();
    press(5'd16);
    press(5'd4); press(5'd14); press(5'd2);
    tests++; if (a !== 40'sd4 || operand !== 3'd4 || entry_value !== 40'sd2) begin
      fails++; $display("FAIL rc_pre: a=%0d op=%0d ev=%0d want 4/4/2", a, operand, entry_value); end
    #2 rst = 1'b1;
    #1;
    tests++; if (a !== 40'sd0 || operand !== 3'd0 || entry_value !== 40'sd0 || digit_cnt !== 4'd0) begin
      fails++; $display("FAIL rc_async: a=%0d op=%0d ev=%0d cnt=%0d want 0", a, operand, entry_value, digit_cnt); end
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'd5;
    @(negedge clk);
    key_valid = 1'b0; key_code = '0;
    rst = 1'b0;
    tests++; if (entry_value !== 40'sd0 || digit_cnt !== 4'd0) begin
      fails++; $display("FAIL rc_lost: ev=%0d cnt=%0d want 0/0", entry_value, digit_cnt); end
    @(negedge clk);
    press(5'd4); press(5'd14); press(5'd16);
    tests++; if (entry_value !== 40'sd0 || a !== 40'sd0 || operand !== 3'd0 || op_valid !== 1'b0) begin
      fails++; $display("FAIL rc_clear: ev=%0d a=%0d op=%0d opv=%b want 0", entry_value, a, operand, op_valid); end
    press(5'd3); press(5'd10);
    tests++; if (a !== 40'sd3 || key_err !== 1'b0 || operand !== 3'd0) begin
      fails++; $display("FAIL rc_state: a=%0d err=%b op=%0d want 3/0/0", a, key_err, operand); end
  endtask

  task automatic test_back_to_back();
    press(5'd16);
    press(5'd9); press(5'd11); press(5'd9); press(5'd15); press(5'd12);
    tests++; if (a !== 40'sd0 || operand !== 3'd2 || b !== 40'sd9 || op_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_chain: a=%0d op=%0d b=%0d opv=%b want 0/2/9/0", a, operand, b, op_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_negate_chain();
    test_digit_limit();
    test_op_replace();
    test_bad_keys();
    test_reset_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
